neuron_mac_seq: RTL and testbench

Operation sequencer that drives the 16-bit ALU port (operands, enable, op select) to evaluate one autoencoder neuron: acc = bias + Σ x_i·w_i. It accepts operand pairs from the weight/activation buffers over a valid/ready stream and issues one multiply and one add to the ALU per term. It returns the accumulated value, optionally passed through ReLU, over a valid/ready output. It sits between the layer controller and the ALU. The ALU itself is instantiated outside this block.

---
 rtl/neuron_pkg.sv | 22 ++
 rtl/neuron_mac_seq.sv | 151 +++++++++++++++
 tb/tb_neuron_mac_seq.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// neuron_pkg
// Shared definitions for the neuron MAC sequencer:
//   - neuron_state_t : sequencer state encoding
//   - ALU_OP_*       : op-select codes understood by the external 16-bit ALU
//   - DATA_W_DEFAULT : default operand/result width (must match the ALU)
package neuron_pkg;

    localparam int DATA_W_DEFAULT = 16;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;
    localparam logic [1:0] ALU_OP_MUL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_MULT  = 3'd2,
        S_ADD   = 3'd3,
        S_DONE  = 3'd4
    } neuron_state_t;

endpackage

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq
// Sequences the external ALU to evaluate one neuron: acc = bias + sum(x_i * w_i).
// Each term is fetched over a valid/ready stream, then one multiply and one add
// are issued to the ALU. The final accumulator is returned over valid/ready.
//
// Optional feature macro: NEURON_RELU_EN
//   defined     -> out_data = ReLU(acc) (negative two's-complement values become 0)
//   not defined -> out_data = acc
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, n_inputs, bias neuron request (sampled only in IDLE)
//   in_valid/in_ready     operand-pair handshake, in_x / in_w payload
//   alu_op1/op2/en/sel    drive the ALU; alu_result is its combinational result
//   out_valid/out_ready   result handshake, out_data payload
//   busy                  high in every state except IDLE
//
// state | meaning
// IDLE  | waiting for start
// FETCH | accepting the next (x, w) pair
// MULT  | ALU computes x_r * w_r, captured into prod
// ADD   | ALU computes acc + prod, captured into acc
// DONE  | presenting result until out_ready
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int N_MAX  = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_inputs,
    input  logic [DATA_W-1:0] bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    output logic [DATA_W-1:0] alu_op1,
    output logic [DATA_W-1:0] alu_op2,
    output logic              alu_en,
    output logic [1:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    neuron_state_t state, state_nxt;

    logic [DATA_W-1:0] acc, prod, x_r, w_r;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  n_clamped;

    assign n_clamped = (n_inputs > CNT_W'(N_MAX)) ? CNT_W'(N_MAX) : n_inputs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            prod <= '0;
            x_r  <= '0;
            w_r  <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc <= bias;
                        cnt <= n_clamped;
                    end
                end
                S_FETCH: begin
                    if (in_valid) begin
                        x_r <= in_x;
                        w_r <= in_w;
                    end
                end
                S_MULT: prod <= alu_result;
                S_ADD: begin
                    acc <= alu_result;
                    cnt <= cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs depend only on registered state/datapath, never on inputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        alu_en    = 1'b0;
        alu_sel   = ALU_OP_ADD;
        alu_op1   = '0;
        alu_op2   = '0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (n_clamped == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_MULT;
                end
            end
            S_MULT: begin
                alu_en    = 1'b1;
                alu_sel   = ALU_OP_MUL;
                alu_op1   = x_r;
                alu_op2   = w_r;
                state_nxt = S_ADD;
            end
            S_ADD: begin
                alu_en    = 1'b1;
                alu_sel   = ALU_OP_ADD;
                alu_op1   = acc;
                alu_op2   = prod;
                state_nxt = (cnt == CNT_W'(1)) ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                out_valid = 1'b1;
`ifdef NEURON_RELU_EN
                out_data  = acc[DATA_W-1] ? '0 : acc;
`else
                out_data  = acc;
`endif
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  n_inputs = '0;
    logic [15:0] bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_x = '0;
    logic [15:0] in_w = '0;
    logic [15:0] alu_op1, alu_op2;
    logic        alu_en;
    logic [1:0]  alu_sel;
    logic [15:0] alu_result;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int checks = 0;
    int passes = 0;

    // Stimulus tables and results of the last run_neuron call
    logic [15:0] px [0:15];
    logic [15:0] pw [0:15];
    logic [15:0] r_data;
    int          r_hs, r_lat;
    bit          r_timeout, r_stable, r_ready_seen, r_idle;

    // Behavioural ALU
    logic [31:0] prod_full;
    assign prod_full  = {16'h0, alu_op1} * {16'h0, alu_op2};
    assign alu_result = (alu_sel == 2'b10) ? prod_full[15:0] : 16'(alu_op1 + alu_op2);

    always #5 clk = ~clk;

    neuron_mac_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n_inputs   (n_inputs),
        .bias       (bias),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_w       (in_w),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_en     (alu_en),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one neuron through to the output handshake; records results, no checks.
    // gap: cycles in_valid stays low after each accepted pair.
    task automatic run_neuron(input int n, input logic [15:0] b, input int gap,
                              input int hold, input bit start_busy);
        int idx;
        int gapc;
        bit hs;
        idx = 0; gapc = 0;
        r_timeout = 0; r_stable = 1; r_ready_seen = 0; r_lat = 0;
        start = 1'b1; n_inputs = 4'(n); bias = b;
        in_valid = 1'b1; in_x = px[0]; in_w = pw[0];
        out_ready = 1'b0;
        tick;
        start = start_busy;
        while (!out_valid && r_lat < 400) begin
            if (in_ready) r_ready_seen = 1;
            hs = in_ready && in_valid;
            tick;
            r_lat++;
            if (hs) begin
                idx++;
                in_x = px[idx % 16];
                in_w = pw[idx % 16];
                if (gap > 0) begin
                    in_valid = 1'b0;
                    gapc = gap;
                end
            end else if (gapc > 0) begin
                gapc--;
                if (gapc == 0) in_valid = 1'b1;
            end
        end
        start = 1'b0;
        if (!out_valid) begin
            r_timeout = 1;
            r_hs = idx;
            return;
        end
        r_data = out_data;
        for (int i = 0; i < hold; i++) begin
            if (in_ready && in_valid) idx++;
            tick;
            if (out_valid !== 1'b1 || out_data !== r_data) r_stable = 0;
        end
        if (in_ready && in_valid) idx++;
        r_hs = idx;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        in_valid = 1'b0;
        r_idle = !busy && !out_valid && !in_ready;
    endtask

    task automatic test_reset;
        checks++;
        if ({busy, in_ready, alu_en, alu_sel, out_valid} !== 6'b0 ||
            alu_op1 !== 16'h0 || alu_op2 !== 16'h0 || out_data !== 16'h0)
            $display("FAIL reset_values: busy=%b rdy=%b en=%b sel=%b op1=%h op2=%h ov=%b od=%h required all zero",
                     busy, in_ready, alu_en, alu_sel, alu_op1, alu_op2, out_valid, out_data);
        else passes++;

        // 3-term neuron, abort while waiting in FETCH
        start = 1'b1; n_inputs = 4'd3; bias = 16'h1234; in_valid = 1'b0;
        tick;
        start = 1'b0;
        tick;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL reset_fetch_entry: in_ready=%b busy=%b required 1 1", in_ready, busy);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, in_ready, alu_en, alu_sel, out_valid} !== 6'b0 || out_data !== 16'h0 ||
            alu_op1 !== 16'h0 || alu_op2 !== 16'h0)
            $display("FAIL reset_abort: busy=%b rdy=%b en=%b sel=%b ov=%b od=%h required all zero",
                     busy, in_ready, alu_en, alu_sel, out_valid, out_data);
        else passes++;
        tick;
        rst = 1'b0;
        tick;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL reset_no_output: out_valid=%b busy=%b required 0 0", out_valid, busy);
        else passes++;

        px[0] = 16'd2; pw[0] = 16'd3;
        run_neuron(1, 16'd1, 0, 0, 0);
        checks++;
        if (r_timeout || r_data !== 16'd7)
            $display("FAIL reset_rerun: out_data=%h timeout=%b required 0007", r_data, r_timeout);
        else passes++;
    endtask

    task automatic test_single_term;
        start = 1'b1; n_inputs = 4'd1; bias = 16'd5;
        in_valid = 1'b1; in_x = 16'd3; in_w = 16'd4; out_ready = 1'b0;
        tick;                       // edge 0: start sampled
        start = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || alu_en !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL single_fetch: in_ready=%b alu_en=%b out_valid=%b required 1 0 0",
                     in_ready, alu_en, out_valid);
        else passes++;
        tick;                       // edge 1: handshake
        in_valid = 1'b0;
        checks++;
        if (alu_en !== 1'b1 || alu_sel !== 2'b10 || alu_op1 !== 16'd3 || alu_op2 !== 16'd4 || in_ready !== 1'b0)
            $display("FAIL single_mult: en=%b sel=%b op1=%h op2=%h rdy=%b required 1 10 0003 0004 0",
                     alu_en, alu_sel, alu_op1, alu_op2, in_ready);
        else passes++;
        tick;
        checks++;
        if (alu_en !== 1'b1 || alu_sel !== 2'b00 || alu_op1 !== 16'd5 || alu_op2 !== 16'd12)
            $display("FAIL single_add: en=%b sel=%b op1=%h op2=%h required 1 00 0005 000c",
                     alu_en, alu_sel, alu_op1, alu_op2);
        else passes++;
        tick;                       // edge 3: out_valid rises
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'd17 || alu_en !== 1'b0)
            $display("FAIL single_done: out_valid=%b out_data=%h alu_en=%b required 1 0011 0",
                     out_valid, out_data, alu_en);
        else passes++;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL single_idle: out_valid=%b busy=%b required 0 0", out_valid, busy);
        else passes++;
    endtask

    task automatic test_zero_terms;
        run_neuron(0, 16'h0042, 0, 0, 0);
        checks++;
        if (r_timeout || r_data !== 16'h0042 || r_lat != 0)
            $display("FAIL zero_terms: out_data=%h latency=%0d required 0042 0", r_data, r_lat);
        else passes++;
        checks++;
        if (r_ready_seen || r_hs != 0)
            $display("FAIL zero_no_fetch: in_ready_seen=%b pairs=%0d required 0 0", r_ready_seen, r_hs);
        else passes++;
    endtask

    task automatic test_stalls;
        px[0] = 16'd1; pw[0] = 16'd2;
        px[1] = 16'd3; pw[1] = 16'd4;
        px[2] = 16'd5; pw[2] = 16'd6;
        // in_valid low 4 cycles after each pair = 2 idle FETCH cycles per later term
        run_neuron(3, 16'd0, 4, 5, 0);
        checks++;
        if (r_timeout || r_data !== 16'd44)
            $display("FAIL stall_result: out_data=%h required 002c", r_data);
        else passes++;
        checks++;
        if (r_lat != 13)
            $display("FAIL stall_latency: cycles=%0d required 13", r_lat);
        else passes++;
        checks++;
        if (!r_stable || r_hs != 3 || !r_idle)
            $display("FAIL stall_hold: stable=%b pairs=%0d idle=%b required 1 3 1", r_stable, r_hs, r_idle);
        else passes++;
    endtask

    task automatic test_relu;
        px[0] = 16'd1; pw[0] = 16'd1;
        run_neuron(1, 16'hFFF0, 0, 0, 0);
        checks++;
`ifdef NEURON_RELU_EN
        if (r_timeout || r_data !== 16'h0000)
            $display("FAIL relu_negative: out_data=%h required 0000", r_data);
        else passes++;
`else
        if (r_timeout || r_data !== 16'hFFF1)
            $display("FAIL linear_negative: out_data=%h required fff1", r_data);
        else passes++;
`endif
    endtask

    task automatic test_clamp_wrap;
        for (int i = 0; i < 16; i++) begin
            px[i] = 16'h0100;
            pw[i] = 16'h0100;
        end
        // start held high while busy; in_valid held high the whole time
        run_neuron(15, 16'h0007, 0, 3, 1);
        checks++;
        if (r_timeout || r_data !== 16'h0007)
            $display("FAIL clamp_result: out_data=%h required 0007", r_data);
        else passes++;
        checks++;
        if (r_hs != 8)
            $display("FAIL clamp_pairs: consumed=%0d required 8", r_hs);
        else passes++;
        checks++;
        if (r_lat != 24 || !r_idle)
            $display("FAIL clamp_latency: cycles=%0d idle=%b required 24 1", r_lat, r_idle);
        else passes++;
    endtask

    task automatic test_back_to_back;
        px[0] = 16'd10; pw[0] = 16'd10;
        run_neuron(1, 16'd0, 0, 0, 0);
        // run_neuron returns in the IDLE cycle right after the handshake
        px[0] = 16'hFFFF; pw[0] = 16'd2;
        run_neuron(1, 16'd3, 0, 0, 0);
        checks++;
        if (r_timeout || r_data !== 16'h0001 || r_lat != 3)
            $display("FAIL back_to_back: out_data=%h latency=%0d required 0001 3", r_data, r_lat);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            px[i] = '0;
            pw[i] = '0;
        end
        rst = 1'b1;
        tick;
        tick;
        test_reset_pre();
    end

    task automatic test_reset_pre;
        // Check reset values while rst is still asserted, then release
        test_reset_values_held();
        rst = 1'b0;
        tick;
        test_reset;
        test_single_term;
        test_zero_terms;
        test_stalls;
        test_relu;
        test_clamp_wrap;
        test_back_to_back;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    endtask

    task automatic test_reset_values_held;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL reset_held: busy=%b in_ready=%b out_valid=%b required 0 0 0",
                     busy, in_ready, out_valid);
        else passes++;
    endtask

endmodule
